// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction-memory interface.
// Accepts a valid/ready stream of 32-bit program words and writes them to text
// memory at consecutive word addresses from BASE_ADDR. It holds the core in reset
// while the image loads and for HOLD_CYCLES cycles after the final write, then
// releases it.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               single-cycle pulse that begins a (re)load
//   s_valid/s_ready     stream handshake; s_data and s_last qualify with it
//   mem_wen/addr/wdata  text memory write port (byte address, word aligned)
//   core_rst_n          active-low reset to the core
//   done                image loaded and core released
//   error               sticky overflow flag, cleared by the next load
//   word_count          words written in the current load
module imem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned HOLD_CYCLES = 4,
    localparam int unsigned CNT_W      = $clog2(DEPTH_WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             mem_wen,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             core_rst_n,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] word_count
);

    localparam int unsigned HOLD_W = 8;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HOLD  = 3'd2,
        RUN   = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              load_entry;
    logic              wr_fire;
    logic              ovf_fire;
    logic [HOLD_W-1:0] hold_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_next = state;
        load_entry = 1'b0;
        wr_fire    = 1'b0;
        ovf_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    load_entry = 1'b1;
                end
            end
            LOAD: begin
                // s_ready is high for the whole of LOAD, so s_valid alone is the handshake
                if (s_valid) begin
                    if (word_count == CNT_FULL) begin
                        // Overflow beats s_last: the word is dropped
                        ovf_fire   = 1'b1;
                        state_next = FAULT;
                    end else begin
                        wr_fire = 1'b1;
                        if (s_last) begin
                            state_next = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = RUN;
                end
            end
            RUN, FAULT: begin
                if (start) begin
                    state_next = LOAD;
                    load_entry = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs and datapath; status outputs decode the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'h0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            hold_cnt   <= '0;
        end else begin
            s_ready    <= (state_next == LOAD);
            core_rst_n <= (state_next == RUN);
            done       <= (state_next == RUN);
            mem_wen    <= wr_fire;

            if (wr_fire) begin
                mem_addr  <= BASE_ADDR + (32'(word_count) << 2);
                mem_wdata <= s_data;
            end

            if (load_entry) begin
                word_count <= '0;
            end else if (wr_fire) begin
                word_count <= word_count + CNT_W'(1);
            end

            if (load_entry) begin
                error <= 1'b0;
            end else if (ovf_fire) begin
                error <= 1'b1;
            end

            // Counts cycles spent in HOLD; zero on the first HOLD cycle
            if (state == HOLD) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with DEPTH_WORDS=4 and HOLD_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check sees the result of the preceding edge.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        error;
    logic [2:0]  word_count;

    int n_cmp = 0;
    int n_err = 0;

    imem_loader #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(4),
        .HOLD_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst_n(core_rst_n),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".s_ready"},    32'(s_ready),    32'd0);
        chk({tag, ".mem_wen"},    32'(mem_wen),    32'd0);
        chk({tag, ".mem_addr"},   mem_addr,        BASE);
        chk({tag, ".mem_wdata"},  mem_wdata,       32'd0);
        chk({tag, ".core_rst_n"}, 32'(core_rst_n), 32'd0);
        chk({tag, ".done"},       32'(done),       32'd0);
        chk({tag, ".error"},      32'(error),      32'd0);
        chk({tag, ".word_count"}, 32'(word_count), 32'd0);
    endtask

    // Present one word for a single cycle and check the resulting write
    task automatic put(input string tag, input logic [31:0] d, input logic last,
                       input logic [31:0] exp_addr, input int exp_wc);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        chk({tag, ".wen"},   32'(mem_wen),    32'd1);
        chk({tag, ".addr"},  mem_addr,        exp_addr);
        chk({tag, ".wdata"}, mem_wdata,       d);
        chk({tag, ".wc"},    32'(word_count), 32'(exp_wc));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // After the final write: three more reset cycles, release on the fourth
    task automatic hold_then_run(input string tag, input bit poke_start);
        for (int i = 1; i <= 3; i++) begin
            start = poke_start && (i == 1);
            tick();
            start = 1'b0;
            chk({tag, ".hold_wen"},  32'(mem_wen),    32'd0);
            chk({tag, ".hold_rstn"}, 32'(core_rst_n), 32'd0);
            chk({tag, ".hold_done"}, 32'(done),       32'd0);
        end
        tick();
        chk({tag, ".rstn"},  32'(core_rst_n), 32'd1);
        chk({tag, ".done"},  32'(done),       32'd1);
        chk({tag, ".ready"}, 32'(s_ready),    32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'h0;
        s_last  = 1'b0;

        // Reset for two cycles
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();
        chk_reset("idle");

        // Basic load of three words
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("basic.ready", 32'(s_ready), 32'd1);
        chk("basic.wen0",  32'(mem_wen), 32'd0);
        put("basic.w0", 32'h0000_0013, 1'b0, 32'h8000_0000, 1);
        put("basic.w1", 32'h0010_0093, 1'b0, 32'h8000_0004, 2);
        put("basic.w2", 32'h0000_006F, 1'b1, 32'h8000_0008, 3);
        chk("basic.ready_off", 32'(s_ready), 32'd0);
        hold_then_run("basic", 1'b0);
        chk("basic.wc_run", 32'(word_count), 32'd3);

        // Reload from RUN with gaps between words and stray start pulses
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("reload.rstn",  32'(core_rst_n), 32'd0);
        chk("reload.done",  32'(done),       32'd0);
        chk("reload.ready", 32'(s_ready),    32'd1);
        chk("reload.wc",    32'(word_count), 32'd0);
        put("gap.w0", 32'hA000_0000, 1'b0, 32'h8000_0000, 1);
        s_data = 32'hDEAD_BEEF;
        s_last = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        s_last = 1'b0;
        chk("gap.idle0", 32'(mem_wen), 32'd0);
        chk("gap.rdy0",  32'(s_ready), 32'd1);
        put("gap.w1", 32'hA000_0001, 1'b0, 32'h8000_0004, 2);
        tick();
        chk("gap.idle1", 32'(mem_wen), 32'd0);
        put("gap.w2", 32'hA000_0002, 1'b0, 32'h8000_0008, 3);
        tick();
        chk("gap.idle2", 32'(mem_wen), 32'd0);
        put("gap.w3", 32'hA000_0003, 1'b1, 32'h8000_000C, 4);
        hold_then_run("gap", 1'b1);
        chk("gap.wc_run", 32'(word_count), 32'd4);

        // Overflow: five words into a four-word memory, last on the fifth
        start = 1'b1;
        tick();
        start = 1'b0;
        put("ovf.w0", 32'hB000_0000, 1'b0, 32'h8000_0000, 1);
        put("ovf.w1", 32'hB000_0001, 1'b0, 32'h8000_0004, 2);
        put("ovf.w2", 32'hB000_0002, 1'b0, 32'h8000_0008, 3);
        put("ovf.w3", 32'hB000_0003, 1'b0, 32'h8000_000C, 4);
        s_valid = 1'b1;
        s_data  = 32'hB000_0004;
        s_last  = 1'b1;
        tick();
        chk("ovf.wen",   32'(mem_wen),    32'd0);
        chk("ovf.error", 32'(error),      32'd1);
        chk("ovf.ready", 32'(s_ready),    32'd0);
        chk("ovf.rstn",  32'(core_rst_n), 32'd0);
        chk("ovf.wc",    32'(word_count), 32'd4);
        chk("ovf.addr",  mem_addr,        32'h8000_000C);
        // s_valid still high in FAULT: nothing happens
        tick();
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("fault.wen",   32'(mem_wen),    32'd0);
        chk("fault.error", 32'(error),      32'd1);
        chk("fault.rstn",  32'(core_rst_n), 32'd0);
        chk("fault.done",  32'(done),       32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("recov.error", 32'(error),      32'd0);
        chk("recov.ready", 32'(s_ready),    32'd1);
        chk("recov.wc",    32'(word_count), 32'd0);
        put("recov.w0", 32'hC000_0000, 1'b1, 32'h8000_0000, 1);
        hold_then_run("recov", 1'b0);

        // Reset asserted right after the second handshake of a load
        start = 1'b1;
        tick();
        start = 1'b0;
        put("mid.w0", 32'hD000_0000, 1'b0, 32'h8000_0000, 1);
        put("mid.w1", 32'hD000_0001, 1'b0, 32'h8000_0004, 2);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hD000_0002;
        tick();
        chk_reset("mid_rst");
        rst = 1'b0;
        tick();
        s_valid = 1'b0;
        chk_reset("mid_idle");
        start = 1'b1;
        tick();
        start = 1'b0;
        put("mid.re0", 32'hE000_0000, 1'b0, 32'h8000_0000, 1);
        put("mid.re1", 32'hE000_0001, 1'b1, 32'h8000_0004, 2);
        hold_then_run("mid", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The core only ever reads text memory; this block fills it.
- Accepts 32-bit program words over a valid/ready stream from a host-side source (UART bridge or bench driver).
- Writes each word into text memory at consecutive word addresses starting at the text base.
- Holds the core in reset until the image is loaded, then releases it after a fixed guard interval.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of text memory word 0.
- DEPTH_WORDS, 1024, text memory capacity in words.
- HOLD_CYCLES, 4, cycles between the last write and core reset release; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse that begins a (re)load.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid && s_ready.
- s_data  in  32  program word, little-endian instruction.
- s_last  in  1  marks the final word of the image; qualified by the handshake.
- mem_wen  out  1  text memory write enable.
- mem_addr  out  32  text memory byte address, word aligned.
- mem_wdata  out  32  text memory write data.
- core_rst_n  out  1  active-low reset to the core.
- done  out  1  image loaded and core released.
- error  out  1  sticky overflow flag.
- word_count  out  clog2(DEPTH_WORDS)+1  words written in the current load.

Behaviour:
Reset values:
- State IDLE.
- s_ready=0, mem_wen=0, mem_addr=BASE_ADDR, mem_wdata=0.
- core_rst_n=0, done=0, error=0, word_count=0.
- rst wins over every other input in the same cycle, including mid-load; a partial image is abandoned and the core stays in reset.

FSM states:
- IDLE: s_ready=0, core_rst_n=0. start -> LOAD. On entry to LOAD, word_count is cleared, error is cleared and done is cleared.
- LOAD: s_ready=1, core_rst_n=0. start is ignored.
  - On handshake with word_count < DEPTH_WORDS, the next cycle shows mem_wen=1, mem_addr=BASE_ADDR+4*word_count (pre-increment value) and mem_wdata=s_data. word_count then increments.
  - mem_wen is high for exactly one cycle per accepted word. Back-to-back handshakes give back-to-back writes at 1 word/cycle.
  - Handshake with s_last=1 -> HOLD after that word is written. The write cycle and the first HOLD cycle coincide.
  - Handshake with word_count == DEPTH_WORDS -> word is discarded with no write; error=1; -> FAULT. If s_last accompanies the overflowing word, FAULT still wins.
- HOLD: s_ready=0, core_rst_n=0. An internal counter counts HOLD_CYCLES cycles, then -> RUN.
- RUN: core_rst_n=1, done=1, s_ready=0. start -> LOAD in the next cycle; core_rst_n drops to 0 in that same cycle and done clears.
- FAULT: s_ready=0, core_rst_n=0, error held. start -> LOAD, which clears error.

Datapath rules:
- mem_wen is 0 in all states except the cycle after an accepted, in-range LOAD handshake.
- Address arithmetic is 32-bit with wrap ignored; it cannot overflow because of the DEPTH_WORDS check.
- An empty image is not possible: a load ends only on an s_last handshake or on overflow.
- s_data and s_last are sampled only on the handshake cycle. s_valid without s_ready has no effect.
- word_count holds its final value through HOLD, RUN and FAULT until the next LOAD entry.

Test Plan:
- Basic load: rst 2 cycles, start, stream 3 words 0x00000013, 0x00100093, 0x0000006F (last on 3rd) -> writes to 0x80000000, 0x80000004, 0x80000008. word_count=3. core_rst_n rises exactly 4 cycles after the last mem_wen; done=1.
- Backpressure/gaps: s_valid toggles 1,0,1,0 over 4 words -> exactly 4 single-cycle mem_wen pulses, addresses contiguous, no duplicate or skipped address.
- Overflow with DEPTH_WORDS=4: send 5 words, last on 5th -> 4 writes, 5th word not written, error=1, core_rst_n stays 0, s_ready=0. A following start clears error and loads again from 0x80000000.
- Reset mid-load: assert rst after the 2nd handshake -> next cycle all outputs at reset values, no further mem_wen; start again rewrites from 0x80000000.
- Reload from RUN: after a completed load, pulse start -> core_rst_n=0 and done=0 in the next cycle; new image overwrites from base; core released again after HOLD.
- start pulses during LOAD and HOLD -> ignored; address sequence and release timing unchanged.
